// File: rtl/scancode_decoder.sv
// PS/2 scan-code parser (E0/F0 prefixes, prefix timeout) feeding a first-word-fall-through event FIFO.
// Defining SCANCODE_TYPEMATIC_FILTER_EN drops repeated make events of the last pressed key.
module scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] scan_code,
  input  logic       ev_ready,
  input  logic       ovf_clr,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       ev_overflow,
  output logic [4:0] ev_count
);
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    DEPTH5   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          byte_vld, is_prefix, is_ignored, tmo_hit;
  logic          evt_vld, evt_ext, evt_rel;
  logic          push_req, push, pop, full;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head;

  assign byte_vld   = scan_code != 8'h00;
  assign is_prefix  = (scan_code == 8'hE0) || (scan_code == 8'hF0);
  assign is_ignored = (scan_code == 8'hFA) || (scan_code == 8'hAA) || (scan_code == 8'hEE) ||
                      (scan_code == 8'hFE) || (scan_code == 8'hFC) || (scan_code == 8'hE1);
  // A byte in the timeout cycle wins, so the timeout only fires on an empty cycle.
  assign tmo_hit    = (state != IDLE) && !byte_vld && (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_vld) begin
      case (state)
        IDLE: begin
          if (scan_code == 8'hE0)      state_nxt = EXT;
          else if (scan_code == 8'hF0) state_nxt = BRK;
        end
        EXT: begin
          if (scan_code == 8'hF0)      state_nxt = EXT_BRK;
          else if (scan_code != 8'hE0) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    evt_vld = 1'b0;
    evt_ext = 1'b0;
    evt_rel = 1'b0;
    if (byte_vld) begin
      case (state)
        IDLE:    evt_vld = !is_prefix && !is_ignored;
        EXT:     begin evt_vld = !is_prefix; evt_ext = 1'b1; end
        BRK:     begin evt_vld = !is_prefix; evt_rel = 1'b1; end
        EXT_BRK: begin evt_vld = !is_prefix; evt_ext = 1'b1; evt_rel = 1'b1; end
        default: evt_vld = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                tmo_cnt <= '0;
    else if (byte_vld || state == IDLE || tmo_hit) tmo_cnt <= '0;
    else                                       tmo_cnt <= tmo_cnt + TW'(1);
  end

`ifdef SCANCODE_TYPEMATIC_FILTER_EN
  logic       rec_vld;
  logic [8:0] rec;
  logic       rec_match;

  assign rec_match = rec_vld && (rec == {evt_ext, scan_code});
  assign push_req  = evt_vld && !(rec_match && !evt_rel);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rec_vld <= 1'b0;
      rec     <= '0;
    end else if (push && !evt_rel) begin
      rec_vld <= 1'b1;
      rec     <= {evt_ext, scan_code};
    end else if (evt_vld && evt_rel && rec_match) begin
      rec_vld <= 1'b0;
      rec     <= '0;
    end
  end
`else
  assign push_req = evt_vld;
`endif

  assign ev_valid = ev_count != 5'd0;
  assign full     = ev_count == DEPTH5;
  assign pop      = ev_valid && ev_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {evt_ext, evt_rel, scan_code};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ev_count    <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   ev_count <= ev_count + 5'd1;
        2'b01:   ev_count <= ev_count - 5'd1;
        default: ev_count <= ev_count;
      endcase
      if (push_req && full && !pop) ev_overflow <= 1'b1;
      else if (ovf_clr)             ev_overflow <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr];
  assign ev_code    = ev_valid ? head[7:0] : 8'h00;
  assign ev_release = ev_valid && head[8];
  assign ev_ext     = ev_valid && head[9];

endmodule

// File: tb/tb_scancode_decoder.sv
// Directed table-driven bench for scancode_decoder plus timeout, typematic and reset sequences.
module tb_scancode_decoder;
  localparam int TMO = 16;

  logic       CLK, RST_N;
  logic [7:0] scan_code;
  logic       ev_ready, ovf_clr;
  logic       ev_valid, ev_ext, ev_release, ev_overflow;
  logic [7:0] ev_code;
  logic [4:0] ev_count;

  int checks = 0;
  int errors = 0;

  scancode_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .scan_code(scan_code), .ev_ready(ev_ready), .ovf_clr(ovf_clr),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_release(ev_release),
    .ev_overflow(ev_overflow), .ev_count(ev_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  sc;
    logic        rdy;
    logic        clr;
    logic [16:0] exp;
  } vec_t;

  vec_t vq[$];

  // Packed view: {valid, ext, release, overflow, count[4:0], code[7:0]}
  function automatic logic [16:0] pk(logic v, logic [7:0] code, logic ext, logic rel, logic ovf,
                                     logic [4:0] cnt);
    return {v, ext, rel, ovf, cnt, code};
  endfunction

  function automatic vec_t mk(logic [7:0] sc, logic rdy, logic clr, logic v, logic [7:0] code,
                              logic ext, logic rel, logic ovf, logic [4:0] cnt);
    vec_t r;
    r.sc = sc; r.rdy = rdy; r.clr = clr;
    r.exp = pk(v, code, ext, rel, ovf, cnt);
    return r;
  endfunction

  function automatic logic [16:0] obs();
    return {ev_valid, ev_ext, ev_release, ev_overflow, ev_count, ev_code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] tbytes [5];
  int nev, nrel, exp_nev;

  initial begin
    RST_N = 1'b1; scan_code = 8'h00; ev_ready = 1'b0; ovf_clr = 1'b0;
    #1 RST_N = 1'b0;
    #2 check("reset_outputs", 32'(obs()), 32'(pk(0, 8'h00, 0, 0, 0, 5'd0)));
    tick(); tick();
    RST_N = 1'b1;

    // make / break
    vq.push_back(mk(8'h1C, 1, 0, 1, 8'h1C, 0, 0, 0, 1));
    vq.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'hF0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'h1C, 1, 0, 1, 8'h1C, 0, 1, 0, 1));
    vq.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    // extended make / break
    vq.push_back(mk(8'hE0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'h75, 1, 0, 1, 8'h75, 1, 0, 0, 1));
    vq.push_back(mk(8'hE0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'hF0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'h75, 1, 0, 1, 8'h75, 1, 1, 0, 1));
    vq.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    // ignored byte in IDLE, then a normal make
    vq.push_back(mk(8'hFA, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'h16, 1, 0, 1, 8'h16, 0, 0, 0, 1));
    vq.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    // F0 E0 aborts to IDLE
    vq.push_back(mk(8'hF0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'hE0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'h1C, 1, 0, 1, 8'h1C, 0, 0, 0, 1));
    vq.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    // repeated E0 stays extended
    vq.push_back(mk(8'hE0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'hE0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'h74, 1, 0, 1, 8'h74, 1, 0, 0, 1));
    vq.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    // fill, overflow, clear, full push+pop, overflow vs clear, drain
    vq.push_back(mk(8'h15, 0, 0, 1, 8'h15, 0, 0, 0, 1));
    vq.push_back(mk(8'h1D, 0, 0, 1, 8'h15, 0, 0, 0, 2));
    vq.push_back(mk(8'h24, 0, 0, 1, 8'h15, 0, 0, 0, 3));
    vq.push_back(mk(8'h2D, 0, 0, 1, 8'h15, 0, 0, 0, 4));
    vq.push_back(mk(8'h2C, 0, 0, 1, 8'h15, 0, 0, 1, 4));
    vq.push_back(mk(8'h35, 0, 0, 1, 8'h15, 0, 0, 1, 4));
    vq.push_back(mk(8'h00, 0, 1, 1, 8'h15, 0, 0, 0, 4));
    vq.push_back(mk(8'h3C, 1, 0, 1, 8'h1D, 0, 0, 0, 4));
    vq.push_back(mk(8'h43, 0, 1, 1, 8'h1D, 0, 0, 1, 4));
    vq.push_back(mk(8'h00, 1, 1, 1, 8'h24, 0, 0, 0, 3));
    vq.push_back(mk(8'h00, 1, 0, 1, 8'h2D, 0, 0, 0, 2));
    vq.push_back(mk(8'h00, 1, 0, 1, 8'h3C, 0, 0, 0, 1));
    vq.push_back(mk(8'h44, 1, 0, 1, 8'h44, 0, 0, 0, 1));
    vq.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    vq.push_back(mk(8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0));

    foreach (vq[i]) begin
      scan_code = vq[i].sc; ev_ready = vq[i].rdy; ovf_clr = vq[i].clr;
      tick();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vq[i].exp));
    end
    scan_code = 8'h00; ovf_clr = 1'b0; ev_ready = 1'b1;

    // typematic repeat
    tbytes = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    nev = 0; nrel = 0;
    for (int i = 0; i < 8; i++) begin
      scan_code = (i < 5) ? tbytes[i] : 8'h00;
      tick();
      if (ev_valid) begin
        nev++;
        if (ev_release) nrel++;
      end
    end
`ifdef SCANCODE_TYPEMATIC_FILTER_EN
    exp_nev = 2;
`else
    exp_nev = 4;
`endif
    check("typematic_events", 32'(nev), 32'(exp_nev));
    check("typematic_breaks", 32'(nrel), 32'd1);

    // prefix timeout: E0 is lost
    scan_code = 8'hE0; tick();
    scan_code = 8'h00;
    repeat (TMO) tick();
    check("timeout_no_event", 32'(ev_count), 32'd0);
    scan_code = 8'h1C; tick();
    check("timeout_event", 32'(obs()), 32'(pk(1, 8'h1C, 0, 0, 0, 5'd1)));
    scan_code = 8'h00; tick();

    // byte on the timeout cycle still completes the sequence
    scan_code = 8'hE0; tick();
    scan_code = 8'h00;
    repeat (TMO - 1) tick();
    scan_code = 8'h1C; tick();
    check("timeout_precedence", 32'(obs()), 32'(pk(1, 8'h1C, 1, 0, 0, 5'd1)));
    scan_code = 8'h00; tick();
    check("timeout_drain", 32'(obs()), 32'(pk(0, 8'h00, 0, 0, 0, 5'd0)));

    // reset mid-sequence
    ev_ready = 1'b0;
    scan_code = 8'h29; tick();
    scan_code = 8'hE0; tick();
    scan_code = 8'hF0; tick();
    check("pre_reset", 32'(obs()), 32'(pk(1, 8'h29, 0, 0, 0, 5'd1)));
    scan_code = 8'h75;
    #2 RST_N = 1'b0;
    #1 check("reset_async", 32'(obs()), 32'(pk(0, 8'h00, 0, 0, 0, 5'd0)));
    tick(); tick();
    check("reset_held", 32'(obs()), 32'(pk(0, 8'h00, 0, 0, 0, 5'd0)));
    RST_N = 1'b1;
    tick();
    check("post_reset_event", 32'(obs()), 32'(pk(1, 8'h75, 0, 0, 0, 5'd1)));
    scan_code = 8'h00; ev_ready = 1'b1; tick();
    check("post_reset_drain", 32'(obs()), 32'(pk(0, 8'h00, 0, 0, 0, 5'd0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
